sample_logger: RTL and testbench
================================

SAMPLE_LOGGER -- requirements
Module: sample_logger

Interface
REQ-001 Parameter DW, default 8, sample and memory data width in bits.
REQ-002 Parameter AW, default 4, memory address width; ring depth SHALL be 2**AW (16 entries at default).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 sample_in  input  DW  sensor sample.
REQ-006 sample_valid  input  1  sample_in valid this cycle.
REQ-007 sample_ready  output  1  logger can accept a sample this cycle.
REQ-008 drain_en  input  1  permits draining stored samples to the transmitter.
REQ-009 clr  input  1  synchronous flush request.
REQ-010 tx_data  output  DW  oldest stored sample.
REQ-011 tx_valid  output  1  tx_data valid.
REQ-012 tx_ready  input  1  transmitter accepts tx_data.
REQ-013 mem_addr  output  AW  memory address.
REQ-014 mem_wdata  output  DW  memory write data.
REQ-015 mem_write  output  1  memory write strobe.
REQ-016 mem_read  output  1  memory read strobe.
REQ-017 mem_rdata  input  DW  memory read data, registered by memory one cycle after mem_read.
REQ-018 count  output  AW+1  number of stored samples, 0..2**AW.
REQ-019 drop_cnt  output  8  samples discarded while full, saturating at 255.

Function
REQ-020 FSM states: IDLE, WRITE, RD, RDW, SEND.
REQ-021 sample_ready SHALL be 1 only in IDLE; it is combinational from state.
REQ-022 An accept occurs on sample_valid && sample_ready.
REQ-023 IDLE, accept, count < 2**AW: register sample_in, go to WRITE.
REQ-024 IDLE, accept, count == 2**AW: discard the sample, increment drop_cnt (saturating), stay in IDLE.
REQ-025 WRITE: assert mem_write=1 for exactly one cycle, mem_addr=wr_ptr, mem_wdata=the registered sample; then wr_ptr+1 (mod 2**AW), count+1, go to IDLE.
REQ-026 IDLE, no accept, drain_en=1, count > 0: go to RD; a pending accept SHALL take priority over draining.
REQ-027 RD: assert mem_read=1 for exactly one cycle, mem_addr=rd_ptr; go to RDW.
REQ-028 RDW: capture mem_rdata into tx_data; go to SEND.
REQ-029 SEND: tx_valid=1, tx_data held stable until tx_ready=1.
REQ-030 On tx_ready=1 in SEND: rd_ptr+1 (mod 2**AW), count-1, go to IDLE.
REQ-031 A drain_en drop during RD, RDW or SEND SHALL NOT abort the transfer.
REQ-032 mem_write and mem_read SHALL never be 1 in the same cycle.
REQ-033 mem_addr SHALL equal wr_ptr in WRITE and rd_ptr in all other states.
REQ-034 Pointer wrap-around: 2**AW-1 SHALL advance to 0.
REQ-035 clr=1 in IDLE: wr_ptr, rd_ptr and count SHALL go to 0 on the next edge, with no accept that cycle (sample_ready=0 while clr=1); drop_cnt is unaffected.
REQ-036 clr=1 in any other state SHALL be ignored.
REQ-037 Minimum cost: a stored sample SHALL cost 2 cycles (IDLE+WRITE); a drained sample SHALL cost 4 cycles (IDLE, RD, RDW, SEND) with tx_ready held high.

Reset
REQ-038 While rst=1, regardless of clk: state=IDLE, wr_ptr=0, rd_ptr=0, count=0, drop_cnt=0, tx_data=0, tx_valid=0, mem_write=0, mem_read=0, mem_addr=0, mem_wdata=0.
REQ-039 Reset mid-transfer SHALL abort the transfer immediately (tx_valid to 0 asynchronously); memory contents are not the logger's responsibility.

Verification
REQ-040 Write 0xA5, 0x3C with drain_en=0 -> mem_write pulses at addr 0 then 1, count=2, tx_valid stays 0.
REQ-041 Then drain_en=1, tx_ready=1 -> tx_data 0xA5 then 0x3C, each with a 1-cycle tx_valid; mem_read pulses at addr 0 then 1; count returns to 0.
REQ-042 Fill 16 samples, offer 3 more -> count=16, drop_cnt=3, no mem_write for the dropped samples.
REQ-043 Write/drain 20 samples alternately -> wr_ptr/rd_ptr wrap 15->0, data order preserved.
REQ-044 sample_valid and drain_en both high in IDLE, count=1 -> write first, drain next.
REQ-045 tx_ready=0 for 5 cycles in SEND, then rst pulse -> tx_data held stable while tx_ready=0; at rst: tx_valid=0 and count=0 immediately.
REQ-046 clr pulse with count=7 in IDLE -> count=0, drop_cnt unchanged.

Source files
------------

// File: rtl/sample_logger.sv
// sample_logger: buffers sensor samples in an external single-port ring memory and
// drains them, oldest first, to a transmitter.
//
// Ports:
//   clk, rst          single clock; asynchronous active-high reset
//   sample_in/valid   incoming sample; sample_ready is high only when idle and not clearing
//   drain_en          permits draining stored samples to the transmitter
//   clr               synchronous flush of pointers and count (honoured only when idle)
//   tx_data/valid     oldest stored sample; tx_ready completes the transfer
//   mem_*             external memory port; mem_rdata arrives one cycle after mem_read
//   count             number of stored samples, 0..2**AW
//   drop_cnt          samples discarded while full, saturating at 255
module sample_logger #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] sample_in,
    input  logic          sample_valid,
    output logic          sample_ready,
    input  logic          drain_en,
    input  logic          clr,
    output logic [DW-1:0] tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_write,
    output logic          mem_read,
    input  logic [DW-1:0] mem_rdata,
    output logic [AW:0]   count,
    output logic [7:0]    drop_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRd,
        StRdw,
        StSend
    } state_e;

    // Ring is full when count reaches 2**AW, i.e. only the MSB of count is set.
    localparam logic [AW:0] Full = {1'b1, {AW{1'b0}}};

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    drop_q, drop_d;
    logic [DW-1:0] sample_q, sample_d;
    logic [DW-1:0] tx_data_q, tx_data_d;
    logic          accept;

    // A clear request blocks acceptance so the flush cannot race a new write.
    assign sample_ready = (state_q == StIdle) && !clr;
    assign accept       = sample_valid && sample_ready;

    assign mem_wdata = sample_q;
    assign tx_data   = tx_data_q;
    assign count     = count_q;
    assign drop_cnt  = drop_q;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        drop_d    = drop_q;
        sample_d  = sample_q;
        tx_data_d = tx_data_q;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        tx_valid  = 1'b0;
        mem_addr  = rd_ptr_q;

        unique case (state_q)
            StIdle: begin
                if (clr) begin
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                end else if (accept) begin
                    if (count_q == Full) begin
                        if (drop_q != 8'hFF) begin
                            drop_d = drop_q + 8'd1;
                        end
                    end else begin
                        sample_d = sample_in;
                        state_d  = StWrite;
                    end
                end else if (drain_en && (count_q != '0)) begin
                    state_d = StRd;
                end
            end
            StWrite: begin
                mem_write = 1'b1;
                mem_addr  = wr_ptr_q;
                wr_ptr_d  = wr_ptr_q + 1'b1;
                count_d   = count_q + 1'b1;
                state_d   = StIdle;
            end
            StRd: begin
                mem_read = 1'b1;
                state_d  = StRdw;
            end
            StRdw: begin
                tx_data_d = mem_rdata;
                state_d   = StSend;
            end
            StSend: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    count_d  = count_q - 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            drop_q    <= '0;
            sample_q  <= '0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            drop_q    <= drop_d;
            sample_q  <= sample_d;
            tx_data_q <= tx_data_d;
        end
    end

endmodule

// File: tb/tb_sample_logger.sv
// tb_sample_logger: self-checking bench for sample_logger (DW=8, AW=4) with a registered
// memory model and a scoreboard queue of samples expected on the transmit side.
module tb_sample_logger;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] sample_in = '0;
    logic       sample_valid = 1'b0;
    logic       sample_ready;
    logic       drain_en = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_write;
    logic       mem_read;
    logic [7:0] mem_rdata = '0;
    logic [4:0] count;
    logic [7:0] drop_cnt;

    logic [7:0] mem [0:15];

    typedef struct {
        logic [7:0] data;
        bit         wr;
        logic [3:0] addr;
        logic [4:0] cnt;
        logic [7:0] drop;
    } vec_t;

    vec_t       tab [21];
    logic [7:0] q [$];
    int         total = 0;
    int         bad = 0;

    sample_logger #(.DW(8), .AW(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .drain_en     (drain_en),
        .clr          (clr),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_write    (mem_write),
        .mem_read     (mem_read),
        .mem_rdata    (mem_rdata),
        .count        (count),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    // Memory model: writes and registered reads on the rising edge.
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
        if (mem_read) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] d, input bit wr, input int addr,
                                input int cnt, input int drop);
        vec_t v;
        v.data = d;
        v.wr   = wr;
        v.addr = 4'(addr % 16);
        v.cnt  = 5'(cnt);
        v.drop = 8'(drop);
        return v;
    endfunction

    task automatic chk_reset_outputs();
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_count", count, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
    endtask

    // Offer one sample starting just after a rising edge with the logger idle.
    task automatic put(input vec_t v);
        int n = 0;
        sample_in    = v.data;
        sample_valid = 1'b1;
        @(negedge clk);
        while (!sample_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("ready", sample_ready, 1);
        @(posedge clk);
        #1 sample_valid = 1'b0;
        @(negedge clk);
        chk("wr_strobe", mem_write, v.wr);
        if (v.wr) begin
            chk("wr_addr", mem_addr, v.addr);
            chk("wr_data", mem_wdata, v.data);
            chk("wr_excl", mem_read, 0);
            q.push_back(v.data);
        end
        @(posedge clk);
        #1;
        chk("count", count, v.cnt);
        chk("drop_cnt", drop_cnt, v.drop);
    endtask

    // One full drain transaction with tx_ready high; pops the scoreboard.
    task automatic drain_one(input logic [3:0] exp_addr);
        int n = 0;
        logic [7:0] exp;
        @(negedge clk);
        while (!mem_read && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("rd_strobe", mem_read, 1);
        chk("rd_addr", mem_addr, exp_addr);
        chk("rd_excl", mem_write, 0);
        @(negedge clk);
        chk("rdw_tx_valid", tx_valid, 0);
        @(negedge clk);
        chk("send_tx_valid", tx_valid, 1);
        if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: got tx_data 0x%0h with no sample expected", tx_data);
        end else begin
            exp = q.pop_front();
            chk("tx_data", tx_data, exp);
        end
        @(posedge clk);
        #1 chk("tx_valid_pulse", tx_valid, 0);
    endtask

    initial begin
        int n;

        tab[0] = mk(8'hA5, 1, 0, 1, 0);
        tab[1] = mk(8'h3C, 1, 1, 2, 0);
        for (int i = 0; i < 19; i++) begin
            tab[2 + i] = mk(8'(8'h40 + i), i < 16, 2 + i, (i < 16) ? i + 1 : 16,
                            (i < 16) ? 0 : i - 15);
        end

        // Asynchronous reset, checked before any clock edge and again on a clock.
        #1 rst = 1'b1;
        #2 chk_reset_outputs();
        chk("rst_ready", sample_ready, 1);
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk);
        #1 rst = 1'b0;

        // Two writes with draining disabled.
        for (int i = 0; i < 2; i++) put(tab[i]);
        chk("no_tx_while_off", tx_valid, 0);

        // Drain both back in order.
        drain_en = 1'b1;
        tx_ready = 1'b1;
        drain_one(4'd0);
        drain_one(4'd1);
        drain_en = 1'b0;
        chk("drained_count", count, 0);

        // Fill to 16 and offer three more, which must be dropped.
        for (int i = 2; i < 21; i++) put(tab[i]);
        drain_en = 1'b1;
        for (int i = 0; i < 16; i++) drain_one(4'((2 + i) % 16));
        drain_en = 1'b0;
        chk("fill_drained_count", count, 0);

        // Alternate write/drain across the pointer wrap.
        for (int i = 0; i < 20; i++) begin
            put(mk(8'(8'h80 + i), 1, 2 + i, 1, 3));
            drain_en = 1'b1;
            drain_one(4'((2 + i) % 16));
            drain_en = 1'b0;
        end
        chk("alt_count", count, 0);

        // Sample and drain requested together with one stored: write wins.
        put(mk(8'h11, 1, 6, 1, 3));
        sample_in    = 8'h22;
        sample_valid = 1'b1;
        drain_en     = 1'b1;
        @(negedge clk);
        chk("prio_ready", sample_ready, 1);
        @(posedge clk);
        #1 sample_valid = 1'b0;
        @(negedge clk);
        chk("prio_write", mem_write, 1);
        chk("prio_no_read", mem_read, 0);
        chk("prio_addr", mem_addr, 7);
        q.push_back(8'h22);
        @(posedge clk);
        #1 chk("prio_count", count, 2);
        drain_one(4'd6);
        drain_one(4'd7);
        drain_en = 1'b0;

        // Seven stored, then a clear with a competing sample offer.
        for (int i = 0; i < 7; i++) put(mk(8'(8'hC0 + i), 1, 8 + i, i + 1, 3));
        clr          = 1'b1;
        sample_in    = 8'hEE;
        sample_valid = 1'b1;
        @(negedge clk);
        chk("clr_ready", sample_ready, 0);
        @(posedge clk);
        #1 clr = 1'b0;
        sample_valid = 1'b0;
        chk("clr_count", count, 0);
        chk("clr_drop_cnt", drop_cnt, 3);
        @(negedge clk);
        chk("clr_no_write", mem_write, 0);
        @(posedge clk);
        #1 q.delete();
        put(mk(8'h77, 1, 0, 1, 3));
        drain_en = 1'b1;
        tx_ready = 1'b1;
        drain_one(4'd0);
        drain_en = 1'b0;

        // Stall in SEND, drop drain_en, then reset mid-transfer.
        put(mk(8'h5A, 1, 1, 1, 3));
        tx_ready = 1'b0;
        drain_en = 1'b1;
        n = 0;
        @(negedge clk);
        while (!mem_read && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("stall_rd_strobe", mem_read, 1);
        chk("stall_rd_addr", mem_addr, 1);
        @(negedge clk);
        @(negedge clk);
        chk("stall_tx_valid", tx_valid, 1);
        chk("stall_tx_data", tx_data, 8'h5A);
        drain_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_tx_valid", tx_valid, 1);
            chk("hold_tx_data", tx_data, 8'h5A);
        end
        chk("hold_count", count, 1);
        #2 rst = 1'b1;
        #1 chk("abort_tx_valid", tx_valid, 0);
        chk("abort_count", count, 0);
        chk("abort_drop_cnt", drop_cnt, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        q.delete();

        // drop_cnt saturates at 255.
        for (int i = 0; i < 16; i++) put(mk(8'(i), 1, i, i + 1, 0));
        for (int i = 0; i < 256; i++) put(mk(8'hF0, 0, 0, 16, (i < 255) ? i + 1 : 255));
        chk("sat_drop_cnt", drop_cnt, 8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
